// File: rtl/simple_splitter.sv
// simple_splitter: buffers 2n-bit words in a FIFO and emits each as two n-bit halves, high half first.
module simple_splitter #(
  parameter int WIDTH_DOUT = 8,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      din_vld,
  input  logic [2*WIDTH_DOUT-1:0]   din,
  output logic                      dout_vld,
  output logic [WIDTH_DOUT-1:0]     dout,
  input  logic                      dout_rdy,
  output logic                      overflow,
  output logic [$clog2(DEPTH):0]    level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [2*WIDTH_DOUT-1:0] mem [DEPTH];
  logic [2*WIDTH_DOUT-1:0] word_q, word_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic                    phase_q, phase_d, out_full_q, out_full_d, overflow_q, overflow_d;
  logic                    xfer, pop, full, wr;
  always_comb begin
    xfer       = out_full_q & dout_rdy;
    pop        = (level_q != '0) & (~out_full_q | (xfer & phase_q));
    full       = level_q == LW'(DEPTH);
    // a pop in the same cycle frees the slot, so a full FIFO can still take the word
    wr         = din_vld & (~full | pop);
    overflow_d = overflow_q | (din_vld & ~wr);
    word_d     = pop ? mem[rd_ptr_q] : word_q;
    phase_d    = pop ? 1'b0 : xfer ? ~phase_q : phase_q;
    out_full_d = pop ? 1'b1 : (xfer & phase_q) ? 1'b0 : out_full_q;
    wr_ptr_d   = wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q + LW'(wr) - LW'(pop);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_q     <= '0;
      phase_q    <= 1'b0;
      out_full_q <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      word_q     <= word_d;
      phase_q    <= phase_d;
      out_full_q <= out_full_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr_q] <= din;
  end
  assign dout     = phase_q ? word_q[WIDTH_DOUT-1:0] : word_q[2*WIDTH_DOUT-1:WIDTH_DOUT];
  assign dout_vld = out_full_q;
  assign overflow = overflow_q;
  assign level    = level_q;
endmodule

// File: tb/tb_simple_splitter.sv
// tb_simple_splitter: scoreboard bench; expected halves are queued at strobe time and checked on each transfer.
module tb_simple_splitter;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        din_vld = 1'b0;
  logic [15:0] din = '0;
  logic        dout_vld;
  logic [7:0]  dout;
  logic        dout_rdy = 1'b0;
  logic        overflow;
  logic [2:0]  level;
  logic [7:0]  exp_q [$];
  int          errors = 0;
  int          checks = 0;

  simple_splitter #(.WIDTH_DOUT(8), .DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .din_vld(din_vld), .din(din),
    .dout_vld(dout_vld), .dout(dout), .dout_rdy(dout_rdy),
    .overflow(overflow), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w, input bit keep);
    din_vld = 1'b1;
    din = w;
    if (keep) begin
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
    end
    step();
    din_vld = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din_vld = 1'($urandom);
      din = 16'($urandom);
      dout_rdy = 1'($urandom);
      step();
      chk("rst_vld", dout_vld, 0);
      chk("rst_dout", dout, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_level", level, 0);
    end
    din_vld = 1'b0;
    dout_rdy = 1'b0;
    exp_q.delete();
    rstn = 1'b1;
    step();
  endtask

  task automatic drain(input int budget);
    dout_rdy = 1'b1;
    for (int i = 0; i < budget && dout_vld; i++) step();
    chk("drain_done", dout_vld, 0);
    chk("drain_queue", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rstn && dout_vld && dout_rdy) begin
      if (exp_q.size() == 0) chk("spurious", dout, 32'hdead);
      else chk("data", dout, exp_q.pop_front());
    end
  end

  initial begin
    do_reset();
    // single word
    dout_rdy = 1'b1;
    send(16'hABCD, 1);
    chk("single_lat", dout_vld, 0);
    chk("single_lvl", level, 1);
    step();
    chk("single_v1", dout_vld, 1);
    chk("single_hi", dout, 8'hAB);
    step();
    chk("single_v2", dout_vld, 1);
    chk("single_lo", dout, 8'hCD);
    step();
    chk("single_end", dout_vld, 0);
    // backpressure
    dout_rdy = 1'b0;
    send(16'hABCD, 1);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld", dout_vld, 1);
      chk("bp_hold", dout, 8'hAB);
      step();
    end
    dout_rdy = 1'b1;
    chk("bp_hi", dout, 8'hAB);
    step();
    chk("bp_lo", dout, 8'hCD);
    step();
    chk("bp_end", dout_vld, 0);
    // overflow
    dout_rdy = 1'b0;
    for (int i = 1; i <= 6; i++) send({8'(i), 8'(i)}, i <= 5);
    chk("ovf_level", level, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", dout, 8'h01);
    dout_rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("ovf_nogap", dout_vld, 1);
      step();
    end
    chk("ovf_empty", dout_vld, 0);
    chk("ovf_sticky", overflow, 1);
    chk("ovf_lvl0", level, 0);
    // full with simultaneous pop
    do_reset();
    for (int i = 1; i <= 5; i++) send({4'(i), 4'h0, 4'(i), 4'h1}, 1);
    chk("fp_level", level, 4);
    dout_rdy = 1'b1;
    step();
    send(16'h7788, 1);
    chk("fp_level_hold", level, 4);
    chk("fp_no_ovf", overflow, 0);
    drain(30);
    chk("fp_ovf_end", overflow, 0);
    // reset mid-operation
    dout_rdy = 1'b0;
    for (int i = 1; i <= 4; i++) send({8'(i), 8'hE0 + 8'(i)}, 1);
    chk("mid_level", level, 3);
    chk("mid_vld", dout_vld, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_async_vld", dout_vld, 0);
    chk("mid_async_lvl", level, 0);
    chk("mid_async_dout", dout, 0);
    exp_q.delete();
    step();
    rstn = 1'b1;
    dout_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_no_stale", dout_vld, 0);
    end
    send(16'h1234, 1);
    step();
    chk("mid_hi", dout, 8'h12);
    step();
    chk("mid_lo", dout, 8'h34);
    step();
    chk("mid_end", dout_vld, 0);
    chk("final_queue", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/simple_splitter.md
# simple_splitter

Width-halving serializer that sits directly downstream of the n-to-2n adapter. It accepts 2n-bit words on a valid-only strobe with no backpressure and buffers them in a small FIFO. Each word is emitted as two n-bit halves over a valid/ready handshake, high half first. This is the inverse of the adapter packing `{first, second}`, so an adapter→splitter chain reproduces the original n-bit sequence.

## Interface
- `WIDTH_DOUT`, default 8: output half-word width n; input is 2n.
- `DEPTH`, default 4: FIFO depth in 2n-bit words. Power of two, ≥2.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `din_vld`  in  1  input word strobe; no ready is returned.
- `din`  in  2*WIDTH_DOUT  input word, sampled when `din_vld`=1.
- `dout_vld`  out  1  output half valid.
- `dout`  out  WIDTH_DOUT  output half.
- `dout_rdy`  in  1  downstream ready.
- `overflow`  out  1  sticky flag: an input word was dropped.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH. Excludes the output register.

## Operation
- **Storage.** DEPTH-entry FIFO plus one output word register (`word`, `out_full`, `phase`).
- **Write.** Accepted when `din_vld`=1 and (`level`<DEPTH or a FIFO pop occurs in the same cycle).
- **Drop.** If `din_vld`=1 and the FIFO is full with no same-cycle pop, the word is dropped and `overflow` is set to 1. `overflow` clears only on reset.
- **Pop.** A FIFO pop loads the head into `word` with `phase`=0 and `out_full`=1. A pop happens when `level`>0 and either:
  - `out_full`=0, or
  - a transfer completes on `phase`=1.
- **Output mux.**
  - `dout` = `word[2n-1:n]` when `phase`=0.
  - `dout` = `word[n-1:0]` when `phase`=1.
  - `dout_vld` = `out_full`.
- **Transfer.** A transfer occurs when `dout_vld` & `dout_rdy`.
  - On `phase`=0: `phase`←1.
  - On `phase`=1: pop if `level`>0; otherwise `out_full`←0 and `phase`←0.
- **Stability.** While `dout_vld`=1 and `dout_rdy`=0, `dout` and `dout_vld` hold stable.
- **Idle output.** When `dout_vld`=0, `dout` value is don't-care (holds stale data).
- **Level update.** `level` changes by +1 (write only), −1 (pop only) or 0 (both or neither). Read/write pointers wrap modulo DEPTH.

## Timing
- **Reset values.** `dout_vld`=0, `dout`=0, `overflow`=0, `level`=0. Internal `word`=0, `phase`=0, `out_full`=0, pointers=0.
- **Async reset.** Reset takes effect immediately, mid-operation included. All buffered words are discarded.
- **Latency.** `din_vld` sampled at edge t → word in FIFO after t → popped at edge t+1 → `dout_vld`=1 and high half on `dout` after edge t+1, i.e. 2 cycles from input strobe.
- **Throughput.** One half per cycle with `dout_rdy`=1. Sustained input of one word per 2 cycles is lossless. Bursts up to DEPTH+1 words are absorbed with `dout_rdy`=0.
- **Back-to-back words.** No bubble: the low half of word k is followed by the high half of word k+1 on the next cycle when the FIFO is non-empty.
- **Full with simultaneous write and pop.** The write is accepted, `level` is unchanged, and `overflow` is not set.

## Test plan
- **Reset.** Assert `rstn`=0 with random inputs → `dout_vld`=0, `dout`=0x00, `overflow`=0, `level`=0.
- **Single word.** n=8, `dout_rdy`=1, one `din`=0xABCD strobe at edge t → `dout`=0xAB with `dout_vld`=1 after t+1, 0xCD after t+2, `dout_vld`=0 after t+3.
- **Backpressure.** Same word with `dout_rdy`=0 for 5 cycles → `dout`=0xAB held stable. Release → 0xAB, then 0xCD on consecutive cycles.
- **Overflow.** DEPTH=4, `dout_rdy`=0, words 0x0101..0x0606 on consecutive cycles → five accepted, `level`=4, 0x0606 dropped, `overflow`=1. Drain yields 01,01,02,02,…,05,05 with no gaps, then `dout_vld`=0. `overflow` stays 1.
- **Full with simultaneous pop.** FIFO full, transfer on `phase`=1 in the same cycle as `din_vld`=0x7788 → accepted, `level` stays 4, `overflow` stays 0, 0x77 and 0x88 appear last in the drain.
- **Reset mid-operation.** `level`=3 with output valid, then pulse `rstn` low → `dout_vld`=0 and `level`=0 immediately. After release no stale half appears. A new 0x1234 emits 0x12, 0x34.
